// File: rtl/seq_frame_tx.sv
// rtl/seq_frame_tx.sv - serial frame transmitter: preamble, payload MSB first, optional parity
// Optional parity bit after the payload is enabled by defining SEQ_FRAME_TX_PARITY_EN.
module seq_frame_tx #(
  parameter int                DATA_W   = 8,
  parameter int                PRE_W    = 4,
  parameter logic [PRE_W-1:0]  PREAMBLE = 4'b1001
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              x_out,
  output logic              valid,
  output logic              done
);

  localparam int MAX_W = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

`ifdef SEQ_FRAME_TX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_PAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA} state_t;
`endif

  state_t              r_state;
  logic                r_ready;
  logic                r_x;
  logic                r_valid;
  logic                r_done;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic [PRE_W-1:0]    r_pre;
`ifdef SEQ_FRAME_TX_PARITY_EN
  logic                r_par;
`endif

  logic [DATA_W-1:0]   w_data_next;
  logic [PRE_W-1:0]    w_pre_next;

  assign w_data_next = r_shift << 1;
  assign w_pre_next  = r_pre << 1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_x     <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_pre   <= '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift <= data_in;
            r_pre   <= PREAMBLE;
`ifdef SEQ_FRAME_TX_PARITY_EN
            r_par   <= ^data_in;
`endif
            r_x     <= PREAMBLE[PRE_W-1];
            r_valid <= 1'b1;
            r_ready <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_PRE;
          end
        end
        S_PRE: begin
          // r_cnt is the index of the bit currently on x_out
          if (r_cnt == CNT_W'(PRE_W - 1)) begin
            r_x     <= r_shift[DATA_W-1];
            r_cnt   <= '0;
            r_state <= S_DATA;
          end else begin
            r_pre <= w_pre_next;
            r_x   <= w_pre_next[PRE_W-1];
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
            r_x     <= r_par;
            r_state <= S_PAR;
`else
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_x     <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
`endif
          end else begin
            r_shift <= w_data_next;
            r_x     <= w_data_next[DATA_W-1];
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
`ifdef SEQ_FRAME_TX_PARITY_EN
        S_PAR: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_x     <= 1'b0;
          r_ready <= 1'b1;
          r_done  <= 1'b1;
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_x     <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign x_out = r_x;
  assign valid = r_valid;
  assign done  = r_done;

endmodule

// File: tb/tb_seq_frame_tx.sv
// tb/tb_seq_frame_tx.sv - queue-model bench for seq_frame_tx with directed and random frames
module tb_seq_frame_tx;

  localparam int DATA_W = 8;
  localparam int PRE_W  = 4;
  localparam logic [PRE_W-1:0] PRE = 4'b1001;
`ifdef SEQ_FRAME_TX_PARITY_EN
  localparam int FL = PRE_W + DATA_W + 1;
  localparam logic [31:0] LIT_A5 = 32'h134A;
  localparam logic [31:0] LIT_07 = 32'h120F;
`else
  localparam int FL = PRE_W + DATA_W;
  localparam logic [31:0] LIT_A5 = 32'h09A5;
  localparam logic [31:0] LIT_07 = 32'h0907;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic ready, x_out, valid, done;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  seq_frame_tx #(.DATA_W(DATA_W), .PRE_W(PRE_W), .PREAMBLE(PRE)) dut (
    .clock(clock), .reset(reset), .start(start), .data_in(data_in),
    .ready(ready), .x_out(x_out), .valid(valid), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a frame is just a queue of bits drained one per cycle
  bit   q[$];
  logic e_valid = 1'b0, e_x = 1'b0, e_ready = 1'b1, e_done = 1'b0;

  always @(posedge clock) begin
    if (!reset) begin
      q.delete();
      e_valid = 1'b0; e_x = 1'b0; e_ready = 1'b1; e_done = 1'b0;
    end else if (e_ready && start) begin
      q.delete();
      for (int i = PRE_W - 1; i >= 0; i--) q.push_back(PRE[i]);
      for (int i = DATA_W - 1; i >= 0; i--) q.push_back(data_in[i]);
`ifdef SEQ_FRAME_TX_PARITY_EN
      q.push_back(^data_in);
`endif
      e_x = q.pop_front();
      e_valid = 1'b1; e_ready = 1'b0; e_done = 1'b0;
    end else if (e_valid) begin
      if (q.size() > 0) e_x = q.pop_front();
      else begin
        e_valid = 1'b0; e_x = 1'b0; e_ready = 1'b1; e_done = 1'b1;
      end
    end else begin
      e_done = 1'b0; e_x = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("valid", {31'd0, valid}, {31'd0, e_valid});
      chk("x_out", {31'd0, x_out}, {31'd0, e_x});
      chk("ready", {31'd0, ready}, {31'd0, e_ready});
      chk("done",  {31'd0, done},  {31'd0, e_done});
      chk("done_valid_excl", {31'd0, done & valid}, 32'd0);
    end
  end

  logic [31:0] got;
  logic [31:0] got2;
  int n_done;

  initial begin
    // Reset held for two edges with start asserted
    reset = 1'b0; start = 1'b1; data_in = 8'h5A;
    @(negedge clock);
    chk_en = 1'b1;
    @(negedge clock);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_x",     {31'd0, x_out}, 32'd0);
    chk("rst_done",  {31'd0, done},  32'd0);
    reset = 1'b1; start = 1'b0;
    @(negedge clock);

    // Single frame 8'hA5 with an ignored start at frame cycle 5
    start = 1'b1; data_in = 8'hA5;
    @(negedge clock);
    start = 1'b0; data_in = 8'h00;
    got = '0; n_done = 0;
    for (int c = 1; c <= FL + 3; c++) begin
      if (c <= FL) got[FL-c] = x_out;
      if (c == FL + 1) begin
        chk("a5_done_cycle", {29'd0, done, valid, ready}, 32'b101);
      end
      if (done) n_done++;
      if (c == 5) begin start = 1'b1; data_in = 8'hFF; end
      else start = 1'b0;
      @(negedge clock);
    end
    chk("a5_bits", got, LIT_A5);
    chk("a5_one_done", n_done, 32'd1);

    // Back-to-back: start held in the done cycle
    start = 1'b1; data_in = 8'h3C;
    @(negedge clock);
    start = 1'b0; data_in = 8'h00;
    for (int c = 1; c <= FL; c++) begin
      if (c == FL) chk("b2b_last_valid", {31'd0, valid}, 32'd1);
      @(negedge clock);
    end
    chk("b2b_gap", {30'd0, done, valid}, 32'b10);
    start = 1'b1; data_in = 8'hC3;
    @(negedge clock);
    start = 1'b0; data_in = 8'h00;
    got2 = '0;
    for (int c = 1; c <= FL; c++) begin
      got2[FL-c] = x_out;
      @(negedge clock);
    end
    chk("b2b_payload", {24'd0, got2[FL-PRE_W-1 -: 8]}, 32'h00C3);
    @(negedge clock);

    // Reset mid-frame at frame cycle 7
    start = 1'b1; data_in = 8'hA5;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c < 7; c++) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_out", {28'd0, valid, x_out, ready, done}, 32'b0010);
    reset = 1'b1;
    n_done = 0;
    for (int c = 0; c < 3; c++) begin
      if (done) n_done++;
      @(negedge clock);
    end
    chk("midrst_no_done", n_done, 32'd0);
    start = 1'b1; data_in = 8'h07;
    @(negedge clock);
    start = 1'b0;
    got = '0;
    for (int c = 1; c <= FL + 1; c++) begin
      if (c <= FL) got[FL-c] = x_out;
      if (c == FL + 1) chk("f07_done", {31'd0, done}, 32'd1);
      @(negedge clock);
    end
    chk("f07_bits", got, LIT_07);

    // Random traffic against the queue model
    for (int k = 0; k < 600; k++) begin
      reset   = ($urandom_range(0, 59) != 0);
      start   = ($urandom_range(0, 3) == 0);
      data_in = DATA_W'($urandom);
      @(negedge clock);
    end
    reset = 1'b1; start = 1'b0;
    repeat (FL + 3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
- Serial frame transmitter; generates the single-bit stream that the team's serial sequence detectors consume.
- Accepts a parallel data word with a start handshake.
- Emits a fixed preamble pattern, MSB first, so a downstream detector can flag frame start.
- Then emits the data word MSB first, optionally followed by a parity bit, and signals completion.

Parameters:
- DATA_W, 8, width of the payload word; must be >= 1.
- PRE_W, 4, width of the preamble; must be >= 1.
- PREAMBLE, 4'b1001, preamble bit pattern, PRE_W bits wide, transmitted MSB first.

Ports:
- clock  input  1  system clock; all logic updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
- start  input  1  request to send; accepted only when ready=1.
- data_in  input  DATA_W  payload word; captured on the accepting edge.
- ready  output  1  high when idle and able to accept start.
- x_out  output  1  serial bit stream; registered.
- valid  output  1  high while x_out carries a frame bit; registered.
- done  output  1  one-cycle pulse after the last frame bit.

Behaviour:
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset: reset=0 at a rising edge forces state=IDLE, ready=1, x_out=0, valid=0, done=0, bit counter=0 and shift register=0 after that edge. Reset takes priority over every other input.
- States: IDLE, PRE, DATA (plus PAR when PARITY_EN is defined).
- IDLE:
  - ready=1, valid=0, x_out=0.
  - start=1 at an edge: capture data_in, set ready=0, valid=1, x_out=PREAMBLE[PRE_W-1], counter=0, go to PRE.
- PRE:
  - Each edge presents the next preamble bit, MSB to LSB.
  - After PRE_W bits have been presented, the next edge presents data bit DATA_W-1 and moves to DATA.
- DATA:
  - Shift register shifts left; each edge presents the next data bit, MSB to LSB.
  - After DATA_W bits, the next edge performs the frame-end action.
- Frame end: state=IDLE, valid=0, x_out=0, ready=1, done=1 for exactly one cycle.
- Latency:
  - Frame bit i (0-based) is visible in cycle i+1 after the accepting edge.
  - valid is high for exactly PRE_W+DATA_W consecutive cycles (+1 with parity).
- Back-to-back frames: start=1 in the done cycle is accepted. This gives exactly one idle cycle (valid=0, x_out=0) between frames.
- Ignored inputs:
  - start while ready=0 is ignored and is not queued.
  - data_in changes after capture do not affect the frame.
- Idle line level: x_out=0 whenever valid=0.
- Reset mid-frame: the frame aborts at the reset edge, outputs take their reset values, and no done pulse is produced.
- Counter width: $clog2 of max(PRE_W, DATA_W)+1 bits; no wrap occurs within a frame.
- done and valid are never high in the same cycle.

Optional Feature:
- Macro: SEQ_FRAME_TX_PARITY_EN.
- Defined:
  - After the last data bit, state PAR presents one extra bit: even parity, i.e. the XOR of the captured data_in.
  - valid stays high for that cycle; frame length is PRE_W+DATA_W+1.
  - done follows the parity bit.
- Undefined: no PAR state and no parity logic; frame length is PRE_W+DATA_W.

Test Plan:
- Reset: hold reset=0 for 2 edges with start=1 → ready=1, valid=0, x_out=0, done=0; no frame starts.
- Single frame: data_in=8'hA5, start for 1 cycle → x_out over 12 valid cycles = 1,0,0,1,1,0,1,0,0,1,0,1. done=1 in cycle 13 with valid=0 and ready=1.
- Busy start: during that frame, pulse start=1 with data_in=8'hFF at cycle 5 → the frame is unchanged and exactly one done pulse occurs.
- Back-to-back: 8'h3C, then start held high in the done cycle with 8'hC3 → exactly one valid=0 cycle between frames; second payload bits = 1,1,0,0,0,0,1,1.
- Reset mid-frame: reset=0 at frame cycle 7 → next cycle valid=0, x_out=0, ready=1, done=0. A new start after reset releases sends a full frame.
- Parity (macro defined): 8'h07 → 13 valid bits, last bit=1, done in cycle 14. 8'hA5 → last bit=0.
